// File: rtl/data_mem_hs.sv
// -----------------------------------------------------------------------------
// data_mem_hs
//   Byte/halfword/word data memory with a valid/ready request channel and a
//   fixed-latency, non-backpressured response channel. Loads are sign- or
//   zero-extended. Misaligned accesses, the reserved width code and
//   out-of-range addresses are answered with an error response one cycle
//   after accept, and never write the RAM.
//
//   Handshake: a request is accepted on a rising edge where req_valid_i and
//   req_ready_o are both high. Only one request is outstanding. req_ready_o is
//   low while a load waits in BUSY and high in IDLE and in the response cycle,
//   so a new request can be accepted in the same cycle a response is given.
//   rsp_valid_o is a single-cycle pulse that cannot be stalled.
//
//   Optional build macro: DATA_MEM_CLEAR_EN
//     When defined, every reset release is followed by a sweep that writes
//     zero to each word (one per cycle); req_ready_o stays low until it ends.
//
// Parameters:
//   DEPTH_WORDS   number of 32-bit words (power of two, 16..65536)
//   READ_LATENCY  cycles from accepting edge to load response (1..4)
//
// Ports:
//   clk_i           clock, rising edge
//   reset_i         synchronous active-high reset
//   req_valid_i     request present
//   req_ready_o     request can be accepted
//   req_we_i        1 = store, 0 = load
//   req_width_i     00 word, 01 byte, 10 halfword, 11 reserved
//   req_unsigned_i  zero-extend narrow loads
//   req_addr_i      byte address
//   req_wdata_i     store data (low byte/halfword used for narrow stores)
//   rsp_valid_o     one-cycle response pulse
//   rsp_rdata_o     extended load data; 0 for stores, errors and idle cycles
//   rsp_err_o       error flag, meaningful with rsp_valid_o
// -----------------------------------------------------------------------------
module data_mem_hs #(
   parameter int DEPTH_WORDS  = 1024,
   parameter int READ_LATENCY = 2
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_width_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int AW    = IDX_W + 2;
   localparam int CNT_W = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY  = 2'd1,
      S_RESP  = 2'd2,
      S_CLEAR = 2'd3
   } state_e;

   logic [31:0]      mem_q [DEPTH_WORDS];
   state_e           state_q;
   logic             ready_q;
   logic             rsp_valid_q;
   logic             rsp_err_q;
   logic [31:0]      rsp_rdata_q;
   logic [31:0]      hold_q;
   logic [CNT_W-1:0] cnt_q;
`ifdef DATA_MEM_CLEAR_EN
   logic [IDX_W-1:0] clr_idx_q;
`endif

   logic             accept;
   logic             req_err;
   logic             wr_en;
   logic [IDX_W-1:0] idx;
   logic [31:0]      rd_word;
   logic [7:0]       rd_byte;
   logic [15:0]      rd_half;
   logic [31:0]      load_ext;
   logic [31:0]      wr_data;
   logic [3:0]       wr_be;

   // Request decode: error check, load lane extraction and store lane enables.
   always_comb begin
      accept  = req_valid_i && ready_q;
      idx     = req_addr_i[AW-1:2];
      req_err = 1'b0;
      case (req_width_i)
         2'b00:   req_err = (req_addr_i[1:0] != 2'b00);
         2'b01:   req_err = 1'b0;
         2'b10:   req_err = req_addr_i[0];
         default: req_err = 1'b1;
      endcase
      // Any set bit above the RAM's byte-address range is out of range.
      if (req_addr_i[31:AW] != '0) req_err = 1'b1;
      wr_en = accept && req_we_i && !req_err;

      // The RAM word is read combinationally at the accepting edge; the
      // extended result is either returned directly (L=1) or held.
      rd_word = mem_q[idx];
      rd_byte = rd_word[{req_addr_i[1:0], 3'b000} +: 8];
      rd_half = req_addr_i[1] ? rd_word[31:16] : rd_word[15:0];
      case (req_width_i)
         2'b01:   load_ext = req_unsigned_i ? {24'h0, rd_byte}
                                            : {{24{rd_byte[7]}}, rd_byte};
         2'b10:   load_ext = req_unsigned_i ? {16'h0, rd_half}
                                            : {{16{rd_half[15]}}, rd_half};
         default: load_ext = rd_word;
      endcase

      // Narrow store data is replicated into every lane; the enables pick one.
      case (req_width_i)
         2'b00: begin
            wr_be   = 4'hF;
            wr_data = req_wdata_i;
         end
         2'b01: begin
            wr_be   = 4'b0001 << req_addr_i[1:0];
            wr_data = {4{req_wdata_i[7:0]}};
         end
         2'b10: begin
            wr_be   = req_addr_i[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{req_wdata_i[15:0]}};
         end
         default: begin
            wr_be   = 4'b0000;
            wr_data = req_wdata_i;
         end
      endcase
   end

   // RAM array: never reset, written by stores and (optionally) the clear sweep.
   always_ff @(posedge clk_i) begin
`ifdef DATA_MEM_CLEAR_EN
      if (!reset_i && state_q == S_CLEAR) begin
         mem_q[clr_idx_q] <= '0;
      end
`endif
      if (!reset_i && wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem_q[idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   // Control FSM with registered outputs.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
`ifdef DATA_MEM_CLEAR_EN
         state_q   <= S_CLEAR;
         clr_idx_q <= '0;
`else
         state_q   <= S_IDLE;
`endif
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         hold_q      <= '0;
         cnt_q       <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         case (state_q)
            S_IDLE, S_RESP: begin
               if (accept) begin
                  if (req_we_i || req_err) begin
                     state_q     <= S_RESP;
                     ready_q     <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= req_err;
                  end else if (READ_LATENCY == 1) begin
                     state_q     <= S_RESP;
                     ready_q     <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= load_ext;
                  end else begin
                     state_q <= S_BUSY;
                     ready_q <= 1'b0;
                     hold_q  <= load_ext;
                     cnt_q   <= CNT_W'(READ_LATENCY - 2);
                  end
               end else begin
                  // Also the path that raises ready one cycle after reset.
                  state_q <= S_IDLE;
                  ready_q <= 1'b1;
               end
            end
            S_BUSY: begin
               if (cnt_q == '0) begin
                  state_q     <= S_RESP;
                  ready_q     <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= hold_q;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_CLEAR: begin
`ifdef DATA_MEM_CLEAR_EN
               clr_idx_q <= clr_idx_q + 1'b1;
               if (clr_idx_q == IDX_W'(DEPTH_WORDS - 1)) begin
                  state_q <= S_IDLE;
                  ready_q <= 1'b1;
               end
`else
               state_q <= S_IDLE;
               ready_q <= 1'b1;
`endif
            end
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready_o = ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_hs.sv
// -----------------------------------------------------------------------------
// tb_data_mem_hs
//   Self-checking bench for data_mem_hs (DEPTH_WORDS=1024, READ_LATENCY=2).
//   A response monitor pops an expected {due cycle, err, data} record for every
//   rsp_valid_o pulse; requests push those records when they are driven.
// -----------------------------------------------------------------------------
module tb_data_mem_hs;

   localparam int DEPTH = 1024;
   localparam int RL    = 2;
`ifdef DATA_MEM_CLEAR_EN
   localparam int RDY_DLY = DEPTH;
`else
   localparam int RDY_DLY = 1;
`endif
   localparam int W = 65;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [1:0]  req_width_i;
   logic        req_unsigned_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;

   data_mem_hs #(
      .DEPTH_WORDS  (DEPTH),
      .READ_LATENCY (RL)
   ) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_we_i       (req_we_i),
      .req_width_i    (req_width_i),
      .req_unsigned_i (req_unsigned_i),
      .req_addr_i     (req_addr_i),
      .req_wdata_i    (req_wdata_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_rdata_o    (rsp_rdata_o),
      .rsp_err_o      (rsp_err_o)
   );

   // Clock and cycle counter (cyc = number of rising edges so far).
   always #5 clk_i = ~clk_i;
   int cyc = 0;
   always @(posedge clk_i) cyc = cyc + 1;

   typedef struct {
      logic        we;
      logic [1:0]  width;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] data;
   } vec_t;

   vec_t           vecs[$];
   logic [W-1:0]   exp_q[$];
   int             tests = 0;
   int             fails = 0;
   logic [31:0]    mdl [16];

   function automatic vec_t mk(input logic we, input logic [1:0] width, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic err, input logic [31:0] data);
      vec_t v;
      v.we = we; v.width = width; v.uns = uns; v.addr = addr;
      v.wdata = wdata; v.err = err; v.data = data;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive one request at a negedge once ready is high; it is accepted at the
   // next rising edge. Returns at the negedge after acceptance with valid still
   // asserted, so the caller either sends again or calls release_req.
   task automatic send(input logic we, input logic [1:0] width, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_data,
                       output int acc);
      int budget;
      int lat;
      budget = 0;
      while (!req_ready_o && budget < RDY_DLY + 20) begin
         @(negedge clk_i);
         budget++;
      end
      acc = cyc + 1;
      if (!req_ready_o) begin
         check("ready_timeout", {31'h0, req_ready_o}, 32'h1);
         req_valid_i = 1'b0;
      end else begin
         req_valid_i    = 1'b1;
         req_we_i       = we;
         req_width_i    = width;
         req_unsigned_i = uns;
         req_addr_i     = addr;
         req_wdata_i    = wdata;
         lat = (we || exp_err) ? 1 : RL;
         exp_q.push_back({32'(acc + lat - 1), exp_err, exp_data});
      end
      @(negedge clk_i);
   endtask

   task automatic release_req();
      req_valid_i = 1'b0;
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 20) begin
         @(negedge clk_i);
         budget++;
      end
      check("drain_pending", 32'(exp_q.size()), 32'h0);
   endtask

   // Drop reset at a negedge and check when ready comes up.
   task automatic release_reset(input string tag);
      reset_i = 1'b0;
      check({tag, "_ready_at_release"}, {31'h0, req_ready_o}, 32'h0);
      repeat (RDY_DLY - 1) @(negedge clk_i);
      check({tag, "_ready_early"}, {31'h0, req_ready_o}, 32'h0);
      @(negedge clk_i);
      check({tag, "_ready_up"}, {31'h0, req_ready_o}, 32'h1);
   endtask

   initial begin
      int acc;
      int accs[4];
      vec_t v;

      reset_i        = 1'b1;
      req_valid_i    = 1'b0;
      req_we_i       = 1'b0;
      req_width_i    = 2'b00;
      req_unsigned_i = 1'b0;
      req_addr_i     = '0;
      req_wdata_i    = '0;

      // Response monitor.
      fork
         forever begin
            logic [W-1:0] e;
            @(negedge clk_i);
            if (rsp_valid_o) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_rsp: got rsp_valid_o=1 data 0x%08h, expected no response (cycle %0d)",
                           rsp_rdata_o, cyc);
               end else begin
                  e = exp_q.pop_front();
                  check("rsp_data", rsp_rdata_o, e[31:0]);
                  check("rsp_err", {31'h0, rsp_err_o}, {31'h0, e[32]});
                  check("rsp_cycle", 32'(cyc), e[64:33]);
               end
            end else begin
               check("idle_rdata", rsp_rdata_o, 32'h0);
               check("idle_err", {31'h0, rsp_err_o}, 32'h0);
            end
         end
      join_none

      // Reset state.
      repeat (3) @(negedge clk_i);
      check("reset_ready", {31'h0, req_ready_o}, 32'h0);
      check("reset_valid", {31'h0, rsp_valid_o}, 32'h0);
      release_reset("init");

      // Directed vectors.
      vecs.push_back(mk(1, 2'b00, 0, 32'h40,  32'hDEADBEEF, 0, 32'h0));
      vecs.push_back(mk(0, 2'b00, 0, 32'h40,  32'h0,        0, 32'hDEADBEEF));
      vecs.push_back(mk(1, 2'b01, 0, 32'h41,  32'h00000080, 0, 32'h0));
      vecs.push_back(mk(0, 2'b01, 0, 32'h41,  32'h0,        0, 32'hFFFFFF80));
      vecs.push_back(mk(0, 2'b01, 1, 32'h41,  32'h0,        0, 32'h00000080));
      vecs.push_back(mk(0, 2'b00, 0, 32'h40,  32'h0,        0, 32'hDEAD80EF));
      vecs.push_back(mk(0, 2'b01, 0, 32'h43,  32'h0,        0, 32'hFFFFFFDE));
      vecs.push_back(mk(0, 2'b01, 1, 32'h42,  32'h0,        0, 32'h000000AD));
      vecs.push_back(mk(1, 2'b10, 0, 32'h102, 32'h00001234, 0, 32'h0));
      vecs.push_back(mk(1, 2'b10, 0, 32'h100, 32'h0000ABCD, 0, 32'h0));
      vecs.push_back(mk(0, 2'b00, 0, 32'h100, 32'h0,        0, 32'h1234ABCD));
      vecs.push_back(mk(0, 2'b10, 0, 32'h100, 32'h0,        0, 32'hFFFFABCD));
      vecs.push_back(mk(0, 2'b10, 1, 32'h102, 32'h0,        0, 32'h00001234));
      vecs.push_back(mk(1, 2'b01, 0, 32'h103, 32'h0000007F, 0, 32'h0));
      vecs.push_back(mk(0, 2'b00, 0, 32'h100, 32'h0,        0, 32'h7F34ABCD));
      vecs.push_back(mk(0, 2'b01, 0, 32'h103, 32'h0,        0, 32'h0000007F));
      // Errors, then re-read to show memory unchanged.
      vecs.push_back(mk(1, 2'b00, 0, 32'h42,  32'h11111111, 1, 32'h0));
      vecs.push_back(mk(0, 2'b10, 0, 32'h43,  32'h0,        1, 32'h0));
      vecs.push_back(mk(1, 2'b11, 0, 32'h40,  32'h22222222, 1, 32'h0));
      vecs.push_back(mk(0, 2'b11, 0, 32'h40,  32'h0,        1, 32'h0));
      vecs.push_back(mk(0, 2'b00, 0, DEPTH*4, 32'h0,        1, 32'h0));
      vecs.push_back(mk(1, 2'b00, 0, DEPTH*4, 32'h33333333, 1, 32'h0));
      vecs.push_back(mk(1, 2'b00, 0, 32'h8000_0040, 32'h44444444, 1, 32'h0));
      vecs.push_back(mk(0, 2'b00, 0, 32'h40,  32'h0,        0, 32'hDEAD80EF));
      vecs.push_back(mk(0, 2'b00, 0, 32'h100, 32'h0,        0, 32'h7F34ABCD));

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         send(v.we, v.width, v.uns, v.addr, v.wdata, v.err, v.data, acc);
      end
      release_req();
      drain();

      // Back-to-back loads with valid held: accepts exactly RL cycles apart.
      send(0, 2'b00, 0, 32'h40,  32'h0, 0, 32'hDEAD80EF, accs[0]);
      check("b2b_ready_busy", {31'h0, req_ready_o}, {31'h0, RL == 1});
      send(0, 2'b00, 0, 32'h100, 32'h0, 0, 32'h7F34ABCD, accs[1]);
      check("b2b_ready_busy", {31'h0, req_ready_o}, {31'h0, RL == 1});
      send(0, 2'b01, 1, 32'h40,  32'h0, 0, 32'h000000EF, accs[2]);
      send(0, 2'b10, 0, 32'h102, 32'h0, 0, 32'h00007F34, accs[3]);
      release_req();
      for (int i = 0; i < 3; i++) check("b2b_load_spacing", 32'(accs[i+1] - accs[i]), 32'(RL));
      drain();

      // Back-to-back stores: one per cycle, then RAW reads.
      send(1, 2'b00, 0, 32'h300, 32'hCAFEF00D, 0, 32'h0, accs[0]);
      send(1, 2'b00, 0, 32'h304, 32'h0BADF00D, 0, 32'h0, accs[1]);
      send(0, 2'b00, 0, 32'h304, 32'h0,        0, 32'h0BADF00D, accs[2]);
      send(0, 2'b00, 0, 32'h300, 32'h0,        0, 32'hCAFEF00D, accs[3]);
      release_req();
      check("b2b_store_spacing", 32'(accs[1] - accs[0]), 32'h1);
      check("raw_spacing", 32'(accs[2] - accs[1]), 32'h1);
      drain();

      // Random word traffic against a small model.
      for (int i = 0; i < 16; i++) begin
         mdl[i] = $urandom;
         send(1, 2'b00, 0, 32'h200 + 32'(i*4), mdl[i], 0, 32'h0, acc);
      end
      for (int i = 0; i < 40; i++) begin
         int k;
         k = $urandom_range(0, 15);
         if ($urandom_range(0, 1) == 1) begin
            mdl[k] = $urandom;
            send(1, 2'b00, 0, 32'h200 + 32'(k*4), mdl[k], 0, 32'h0, acc);
         end else begin
            send(0, 2'b00, 0, 32'h200 + 32'(k*4), 32'h0, 0, mdl[k], acc);
         end
      end
      release_req();
      drain();

      // Reset asserted while a load sits in BUSY: no response, data kept.
      send(0, 2'b00, 0, 32'h40, 32'h0, 0, 32'hDEAD80EF, acc);
      reset_i = 1'b1;
      release_req();
      exp_q.delete();
      repeat (2) @(negedge clk_i);
      check("busy_reset_ready", {31'h0, req_ready_o}, 32'h0);
      release_reset("busy");
`ifdef DATA_MEM_CLEAR_EN
      send(0, 2'b00, 0, 32'h40, 32'h0, 0, 32'h0, acc);
      for (int i = 0; i < DEPTH; i++) begin
         send(0, 2'b00, 0, 32'(i*4), 32'h0, 0, 32'h0, acc);
      end
`else
      send(0, 2'b00, 0, 32'h40, 32'h0, 0, 32'hDEAD80EF, acc);
      send(0, 2'b00, 0, 32'h300, 32'h0, 0, 32'hCAFEF00D, acc);
`endif
      release_req();
      drain();

      repeat (3) @(negedge clk_i);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
